// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt request front-end.
package irq_pkg;

  // Default number of request sources; the highest index has the highest priority.
  localparam int N_SRC_DEFAULT = 3;

  // Widest source mask the helper functions accept. Callers zero-extend into it.
  localparam int MAX_SRC = 32;

  typedef logic [MAX_SRC-1:0] src_mask_t;

  // Index of the highest set bit of mask, or -1 when mask is all-zero.
  function automatic int top_index(src_mask_t mask);
    int idx;
    idx = -1;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (mask[i]) idx = i;
    end
    return idx;
  endfunction

  // One-hot mask with bit idx set; all-zero for idx = -1 (or out of range).
  function automatic src_mask_t onehot(int idx);
    src_mask_t m;
    m = '0;
    for (int i = 0; i < MAX_SRC; i++) begin
      m[i] = (i == idx);
    end
    return m;
  endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// Request/grant bundle between the interrupt front-end and its CP0 neighbour.
//
// Handshake: exp_src is a level, not a pulse. It holds its one-hot value until
// the cycle in which take=1 is sampled at a rising clk edge; that edge moves
// the granted source from pending into in_service. take while exp_src=0 is a
// no-op. eret=1 sampled at an edge pops the highest in_service bit; eret while
// in_service=0 is a no-op. Both strobes are one clock wide per event.
interface irq_arbiter_if #(
  parameter int N_SRC = irq_pkg::N_SRC_DEFAULT
);
  logic [N_SRC-1:0] irq_in;
  logic             take;
  logic             eret;
  logic             ovr_clr;
  logic [N_SRC-1:0] exp_src;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] in_service;
  logic [N_SRC-1:0] overrun;

  // Side that drives requests and CP0 strobes (system / testbench).
  modport master (
    output irq_in, take, eret, ovr_clr,
    input  exp_src, pending, in_service, overrun
  );

  // The arbiter itself.
  modport slave (
    input  irq_in, take, eret, ovr_clr,
    output exp_src, pending, in_service, overrun
  );
endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous request line, followed by a
// history flop so a held level produces a single-cycle rise pulse.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the raw line through the synchronizer; remember the last synced value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // hist clears on reset, so a line held high across reset release counts as a new rise.
  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt request front-end for the CP0 exception block: latches request
// edges as pending, resolves priority against the nesting (in-service) mask
// and presents one granted source on exp_src.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int N_SRC       = N_SRC_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  irq_arbiter_if.slave  bus
);

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] in_service_q;
  logic [N_SRC-1:0] overrun_q;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] grant_vec;
  logic [N_SRC-1:0] top_bit;
  logic [N_SRC-1:0] take_clr;
  logic [N_SRC-1:0] eret_clr;
  int               level;
  int               grant_idx;

  // One synchronizer / edge detector per request line.
  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (bus.irq_in[g]),
      .rise (rise[g])
    );
  end

  // Priority resolution from registered state only: a source is eligible when
  // it is pending and strictly above the highest source already in service.
  always_comb begin
    level    = top_index(src_mask_t'(in_service_q));
    eligible = '0;
    for (int i = 0; i < N_SRC; i++) begin
      eligible[i] = pending_q[i] && (i > level);
    end
    grant_idx = top_index(src_mask_t'(eligible));
    grant_vec = N_SRC'(onehot(grant_idx));
    top_bit   = N_SRC'(onehot(level));
    take_clr  = bus.take ? grant_vec : '0;
    eret_clr  = bus.eret ? top_bit : '0;
  end

  // Pending/overrun/nesting registers; new edges win over same-cycle clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q    <= '0;
      in_service_q <= '0;
      overrun_q    <= '0;
    end else begin
      pending_q    <= (pending_q & ~take_clr) | rise;
      overrun_q    <= (bus.ovr_clr ? '0 : overrun_q) | (rise & pending_q & ~take_clr);
      in_service_q <= (in_service_q & ~eret_clr) | take_clr;
    end
  end

  assign bus.exp_src    = grant_vec;
  assign bus.pending    = pending_q;
  assign bus.in_service = in_service_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed, table-driven bench for irq_arbiter (N_SRC=3, SYNC_STAGES=2).
module tb_irq_arbiter;
  import irq_pkg::*;

  localparam int N = 3;

  typedef struct {
    logic [N-1:0] irq;
    logic         take;
    logic         eret;
    logic         clr;
    logic [N-1:0] pend;
    logic [N-1:0] ins;
    logic [N-1:0] ovr;
    logic [N-1:0] exp;
  } vec_t;

  logic clk;
  logic reset;

  irq_arbiter_if #(.N_SRC(N)) bus ();

  irq_arbiter #(
    .N_SRC      (N),
    .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  vec_t           vecs[$];
  logic [4*N-1:0] exp_q[$];
  int             n_checks = 0;
  int             n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic add(input logic [N-1:0] irq, input logic take, input logic eret,
                     input logic clr, input logic [N-1:0] pend, input logic [N-1:0] ins,
                     input logic [N-1:0] ovr, input logic [N-1:0] exp);
    vec_t v;
    v.irq  = irq;
    v.take = take;
    v.eret = eret;
    v.clr  = clr;
    v.pend = pend;
    v.ins  = ins;
    v.ovr  = ovr;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    bus.irq_in  = '0;
    bus.take    = 1'b0;
    bus.eret    = 1'b0;
    bus.ovr_clr = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [4*N-1:0] e);
    check({tag, " pending"},    bus.pending,    e[4*N-1:3*N]);
    check({tag, " in_service"}, bus.in_service, e[3*N-1:2*N]);
    check({tag, " overrun"},    bus.overrun,    e[2*N-1:N]);
    check({tag, " exp_src"},    bus.exp_src,    e[N-1:0]);
  endtask

  // Drive one vector for one clock, then compare just after the edge.
  task automatic apply(input int idx);
    vec_t           v;
    logic [4*N-1:0] e;
    v = vecs[idx];
    bus.irq_in  = v.irq;
    bus.take    = v.take;
    bus.eret    = v.eret;
    bus.ovr_clr = v.clr;
    exp_q.push_back({v.pend, v.ins, v.ovr, v.exp});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_outputs($sformatf("v%0d", idx), e);
  endtask

  // ---------------- test ----------------
  initial begin
    reset = 1'b1;
    drive_idle();

    //   irq   tk er cl  pend  ins   ovr   exp
    // single request on source 0, 3-edge latency, then take
    add(3'b001, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000); // 0
    add(3'b001, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000); // 1
    add(3'b001, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b001); // 2
    add(3'b000, 1, 0, 0, 3'b000, 3'b001, 3'b000, 3'b000); // 3
    // nested higher-priority source 2, then two erets
    add(3'b100, 0, 0, 0, 3'b000, 3'b001, 3'b000, 3'b000); // 4
    add(3'b100, 0, 0, 0, 3'b000, 3'b001, 3'b000, 3'b000); // 5
    add(3'b100, 0, 0, 0, 3'b100, 3'b001, 3'b000, 3'b100); // 6
    add(3'b000, 1, 0, 0, 3'b000, 3'b101, 3'b000, 3'b000); // 7
    add(3'b000, 0, 1, 0, 3'b000, 3'b001, 3'b000, 3'b000); // 8
    add(3'b000, 0, 1, 0, 3'b000, 3'b000, 3'b000, 3'b000); // 9
    // source 2 in service masks a lower request until eret
    add(3'b100, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000); // 10
    add(3'b100, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000); // 11
    add(3'b100, 0, 0, 0, 3'b100, 3'b000, 3'b000, 3'b100); // 12
    add(3'b001, 1, 0, 0, 3'b000, 3'b100, 3'b000, 3'b000); // 13
    add(3'b001, 0, 0, 0, 3'b000, 3'b100, 3'b000, 3'b000); // 14
    add(3'b001, 0, 0, 0, 3'b001, 3'b100, 3'b000, 3'b000); // 15
    add(3'b000, 0, 1, 0, 3'b001, 3'b000, 3'b000, 3'b001); // 16
    add(3'b000, 1, 0, 0, 3'b000, 3'b001, 3'b000, 3'b000); // 17
    add(3'b000, 0, 1, 0, 3'b000, 3'b000, 3'b000, 3'b000); // 18
    // two edges on source 1 with a low gap, no take -> overrun; ovr_clr
    add(3'b010, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000); // 19
    add(3'b010, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000); // 20
    add(3'b010, 0, 0, 0, 3'b010, 3'b000, 3'b000, 3'b010); // 21
    add(3'b000, 0, 0, 0, 3'b010, 3'b000, 3'b000, 3'b010); // 22
    add(3'b000, 0, 0, 0, 3'b010, 3'b000, 3'b000, 3'b010); // 23
    add(3'b010, 0, 0, 0, 3'b010, 3'b000, 3'b000, 3'b010); // 24
    add(3'b010, 0, 0, 0, 3'b010, 3'b000, 3'b000, 3'b010); // 25
    add(3'b010, 0, 0, 0, 3'b010, 3'b000, 3'b010, 3'b010); // 26
    add(3'b000, 0, 0, 1, 3'b010, 3'b000, 3'b000, 3'b010); // 27
    add(3'b000, 1, 0, 0, 3'b000, 3'b010, 3'b000, 3'b000); // 28
    add(3'b000, 0, 1, 0, 3'b000, 3'b000, 3'b000, 3'b000); // 29
    // take and eret together with in_service=001, pending=100
    add(3'b001, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000); // 30
    add(3'b001, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000); // 31
    add(3'b001, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b001); // 32
    add(3'b100, 1, 0, 0, 3'b000, 3'b001, 3'b000, 3'b000); // 33
    add(3'b100, 0, 0, 0, 3'b000, 3'b001, 3'b000, 3'b000); // 34
    add(3'b100, 0, 0, 0, 3'b100, 3'b001, 3'b000, 3'b100); // 35
    add(3'b000, 1, 1, 0, 3'b000, 3'b100, 3'b000, 3'b000); // 36
    // build pending=011 under in_service=100 ahead of the mid-run reset
    add(3'b011, 0, 0, 0, 3'b000, 3'b100, 3'b000, 3'b000); // 37
    add(3'b011, 0, 0, 0, 3'b000, 3'b100, 3'b000, 3'b000); // 38
    add(3'b011, 0, 0, 0, 3'b011, 3'b100, 3'b000, 3'b000); // 39
    // after reset release with irq_in=001 held: new rise, pending 3 edges later
    add(3'b001, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000); // 40
    add(3'b001, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000); // 41
    add(3'b001, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b001); // 42
    // re-arm source 0 so its rise lands on the take cycle: set beats clear
    add(3'b000, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b001); // 43
    add(3'b000, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b001); // 44
    add(3'b001, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b001); // 45
    add(3'b001, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b001); // 46
    add(3'b001, 1, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000); // 47
    // re-arm again so an overrun set lands on an ovr_clr cycle: set beats clear
    add(3'b000, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000); // 48
    add(3'b000, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000); // 49
    add(3'b001, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000); // 50
    add(3'b001, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000); // 51
    add(3'b001, 0, 0, 1, 3'b001, 3'b001, 3'b001, 3'b000); // 52
    add(3'b000, 0, 1, 0, 3'b001, 3'b000, 3'b001, 3'b001); // 53
    add(3'b000, 1, 0, 0, 3'b000, 3'b001, 3'b001, 3'b000); // 54
    add(3'b000, 0, 1, 1, 3'b000, 3'b000, 3'b000, 3'b000); // 55
    // take with nothing granted and eret with nothing in service: no effect
    add(3'b000, 1, 1, 0, 3'b000, 3'b000, 3'b000, 3'b000); // 56

    // Reset values, checked while reset is still asserted.
    #1;
    check_outputs("reset", '0);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 40; i++) apply(i);

    // Asynchronous reset mid-cycle: outputs must clear with no clock edge.
    bus.irq_in  = 3'b001;
    bus.take    = 1'b0;
    bus.eret    = 1'b0;
    bus.ovr_clr = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_outputs("async reset", '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 40; i < vecs.size(); i++) apply(i);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
